fp_dispatch_rob: RTL and testbench

//  Parametrised issue/retire controller for the floating point co-processor.
//  - Accepts operations over a valid/ready port and dispatches each to one of NUM_UNITS functional units (add/sub, mul, sincos, ...).
//  - Tags every op and collects out-of-order unit completions in a reorder buffer.
//  - Returns results strictly in issue order over a valid/ready port.
//  - Replaces the fixed 3-unit input/output decode pair.

---
 rtl/fp_pkg.sv | 21 ++
 rtl/fp_rob.sv | 130 +++++++++++++
 rtl/fp_dispatch_rob.sv | 120 ++++++++++++
 tb/tb_fp_dispatch_rob.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating point co-processor dispatch/reorder block.
package fp_pkg;

  // Default operand/result width of the co-processor datapath.
  localparam int FP_DATA_W = 32;

  // op_sel encodings of the functional units attached by default.
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_MUL = 3'd1;
  localparam logic [2:0] OP_SIN = 3'd2;

  // Layout of one reorder-buffer entry at the default datapath width.
  typedef struct packed {
    logic                 alloc;
    logic                 done;
    logic                 illegal;
    logic                 overflow;
    logic [FP_DATA_W-1:0] result;
  } rob_entry_t;

endpackage

// File: rtl/fp_rob.sv
// Reorder buffer: allocates entries in issue order, accepts out-of-order
// completions from any number of units per cycle and retires from the head.
module fp_rob
  import fp_pkg::*;
#(
  parameter int DATA_W    = FP_DATA_W,
  parameter int NUM_UNITS = 3,
  parameter int ROB_DEPTH = 4,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_alloc_en,
  input  logic                        i_alloc_illegal,
  output logic [TAG_W-1:0]            o_wr_ptr,
  output logic                        o_full,
  output logic [TAG_W:0]              o_count,
  input  logic [NUM_UNITS-1:0]        i_comp_valid,
  input  logic [NUM_UNITS*TAG_W-1:0]  i_comp_tag,
  input  logic [NUM_UNITS*DATA_W-1:0] i_comp_result,
  input  logic [NUM_UNITS-1:0]        i_comp_overflow,
  output logic                        o_comp_err,
  output logic                        o_head_valid,
  output logic [DATA_W-1:0]           o_head_result,
  output logic                        o_head_overflow,
  output logic                        o_head_illegal,
  input  logic                        i_head_ready
);

  logic [ROB_DEPTH-1:0] r_alloc;
  logic [ROB_DEPTH-1:0] r_done;
  logic [ROB_DEPTH-1:0] r_illegal;
  logic [ROB_DEPTH-1:0] r_overflow;
  logic [DATA_W-1:0]    r_result [ROB_DEPTH];
  logic [TAG_W-1:0]     r_wr_ptr;
  logic [TAG_W-1:0]     r_rd_ptr;
  logic [TAG_W:0]       r_count;

  logic [ROB_DEPTH-1:0] w_alloc_nx;
  logic [ROB_DEPTH-1:0] w_done_nx;
  logic [ROB_DEPTH-1:0] w_illegal_nx;
  logic [ROB_DEPTH-1:0] w_overflow_nx;
  logic [DATA_W-1:0]    w_result_nx [ROB_DEPTH];
  logic                 w_err;
  logic                 w_retire;

  assign o_wr_ptr     = r_wr_ptr;
  assign o_count      = r_count;
  assign o_full       = (r_count == (TAG_W+1)'(ROB_DEPTH));
  assign o_comp_err   = w_err;
  assign o_head_valid = r_alloc[r_rd_ptr] && r_done[r_rd_ptr];
  assign w_retire     = o_head_valid && i_head_ready;

  // Payload fields are not reset, so they are masked until the head entry is valid.
  assign o_head_result   = o_head_valid ? r_result[r_rd_ptr] : '0;
  assign o_head_overflow = o_head_valid && r_overflow[r_rd_ptr];
  assign o_head_illegal  = o_head_valid && r_illegal[r_rd_ptr];

  // Next entry state: unit completions, then head retire, then new allocation.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    w_alloc_nx    = r_alloc;
    w_done_nx     = r_done;
    w_illegal_nx  = r_illegal;
    w_overflow_nx = r_overflow;
    w_result_nx   = r_result;
    w_err         = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (i_comp_valid[i]) begin
        // Checking the running done bit also rejects two units reporting the same tag.
        if (r_alloc[i_comp_tag[i*TAG_W +: TAG_W]] && !w_done_nx[i_comp_tag[i*TAG_W +: TAG_W]]) begin
          w_done_nx[i_comp_tag[i*TAG_W +: TAG_W]]     = 1'b1;
          w_overflow_nx[i_comp_tag[i*TAG_W +: TAG_W]] = i_comp_overflow[i];
          w_result_nx[i_comp_tag[i*TAG_W +: TAG_W]]   = i_comp_result[i*DATA_W +: DATA_W];
        end else begin
          w_err = 1'b1;
        end
      end
    end
    if (w_retire) begin
      w_alloc_nx[r_rd_ptr] = 1'b0;
      w_done_nx[r_rd_ptr]  = 1'b0;
    end
    // The caller only allocates when not full, so wr_ptr never aliases the retiring head.
    if (i_alloc_en) begin
      w_alloc_nx[r_wr_ptr]    = 1'b1;
      w_done_nx[r_wr_ptr]     = i_alloc_illegal;
      w_illegal_nx[r_wr_ptr]  = i_alloc_illegal;
      w_overflow_nx[r_wr_ptr] = 1'b0;
      if (i_alloc_illegal) begin
        w_result_nx[r_wr_ptr] = '0;
      end
    end
  end

  // Control state: allocation bits, pointers and occupancy count.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      r_alloc  <= '0;
      r_done   <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_alloc <= w_alloc_nx;
      r_done  <= w_done_nx;
      if (i_alloc_en) begin
        r_wr_ptr <= r_wr_ptr + TAG_W'(1);
      end
      if (w_retire) begin
        r_rd_ptr <= r_rd_ptr + TAG_W'(1);
      end
      case ({i_alloc_en, w_retire})
        2'b10:   r_count <= r_count + (TAG_W+1)'(1);
        2'b01:   r_count <= r_count - (TAG_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload storage.
  always_ff @(posedge clk) begin
    // NOTE: payload storage has no reset; alloc/done gate every read of it.
    r_result   <= w_result_nx;
    r_illegal  <= w_illegal_nx;
    r_overflow <= w_overflow_nx;
  end

endmodule

// File: rtl/fp_dispatch_rob.sv
// Issue/retire controller: decodes op_sel, starts the selected unit, tags the
// op in the reorder buffer and returns results strictly in issue order.
module fp_dispatch_rob
  import fp_pkg::*;
#(
  parameter int DATA_W    = FP_DATA_W,
  parameter int OPSEL_W   = 3,
  parameter int NUM_UNITS = 3,
  parameter int ROB_DEPTH = 4,
  parameter int UNIT_W    = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1,
  parameter int TAG_W     = $clog2(ROB_DEPTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_op1,
  input  logic [DATA_W-1:0]           in_op2,
  input  logic [OPSEL_W-1:0]          in_op_sel,
  output logic [NUM_UNITS-1:0]        u_start,
  output logic [DATA_W-1:0]           u_op1,
  output logic [DATA_W-1:0]           u_op2,
  output logic [OPSEL_W-1:0]          u_mode,
  output logic [TAG_W-1:0]            u_tag,
  input  logic [NUM_UNITS-1:0]        u_busy,
  input  logic [NUM_UNITS-1:0]        u_done,
  input  logic [NUM_UNITS*TAG_W-1:0]  u_done_tag,
  input  logic [NUM_UNITS*DATA_W-1:0] u_result,
  input  logic [NUM_UNITS-1:0]        u_overflow,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_result,
  output logic                        out_overflow,
  output logic                        out_illegal,
  output logic [TAG_W:0]              occupancy,
  output logic                        proto_err
);

  logic [UNIT_W-1:0]  w_unit;
  logic [OPSEL_W-1:0] w_sel_hi;
  logic               w_illegal;
  logic               w_busy;
  logic               w_full;
  logic               w_accept;
  logic               w_start_en;
  logic               w_rob_err;
  logic [TAG_W-1:0]   w_wr_ptr;
  logic               r_proto_err;

  // Legal only when the unit index exists and no bits above it are set.
  assign w_unit    = in_op_sel[UNIT_W-1:0];
  assign w_sel_hi  = in_op_sel >> UNIT_W;
  assign w_illegal = ({1'b0, w_unit} >= (UNIT_W+1)'(NUM_UNITS)) || (w_sel_hi != '0);

  // Busy flag of the addressed unit; an index past NUM_UNITS reads as idle.
  always_comb begin
    w_busy = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (w_unit == UNIT_W'(i)) begin
        w_busy = u_busy[i];
      end
    end
  end

  // Illegal ops never reach a unit, so only a legal op waits on busy.
  assign in_ready   = !w_full && (w_illegal || !w_busy);
  assign w_accept   = in_valid && in_ready;
  assign w_start_en = w_accept && !w_illegal;

  // One-hot start pulse to the addressed unit.
  always_comb begin
    u_start = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      u_start[i] = w_start_en && (w_unit == UNIT_W'(i));
    end
  end

  // Broadcast payload is zeroed when nothing starts so idle outputs read 0.
  assign u_op1  = w_start_en ? in_op1 : '0;
  assign u_op2  = w_start_en ? in_op2 : '0;
  assign u_mode = w_start_en ? in_op_sel : '0;
  assign u_tag  = w_start_en ? w_wr_ptr : '0;

  fp_rob #(
    .DATA_W    (DATA_W),
    .NUM_UNITS (NUM_UNITS),
    .ROB_DEPTH (ROB_DEPTH),
    .TAG_W     (TAG_W)
  ) u_rob (
    .clk             (clk),
    .rst             (rst),
    .i_alloc_en      (w_accept),
    .i_alloc_illegal (w_illegal),
    .o_wr_ptr        (w_wr_ptr),
    .o_full          (w_full),
    .o_count         (occupancy),
    .i_comp_valid    (u_done),
    .i_comp_tag      (u_done_tag),
    .i_comp_result   (u_result),
    .i_comp_overflow (u_overflow),
    .o_comp_err      (w_rob_err),
    .o_head_valid    (out_valid),
    .o_head_result   (out_result),
    .o_head_overflow (out_overflow),
    .o_head_illegal  (out_illegal),
    .i_head_ready    (out_ready)
  );

  // Sticky protocol error: any dropped completion since the last reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_proto_err <= 1'b0;
    end else if (w_rob_err) begin
      r_proto_err <= 1'b1;
    end
  end

  assign proto_err = r_proto_err;

endmodule

// File: tb/tb_fp_dispatch_rob.sv
// Self-checking bench for fp_dispatch_rob: directed scenarios followed by
// randomized traffic, all checked against an in-order queue model.
module tb_fp_dispatch_rob;
  import fp_pkg::*;

  localparam int DW    = 32;
  localparam int NU    = 3;
  localparam int DEPTH = 4;
  localparam int TW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_op1, in_op2;
  logic [2:0]    in_op_sel;
  logic [NU-1:0] u_start;
  logic [DW-1:0] u_op1, u_op2;
  logic [2:0]    u_mode;
  logic [TW-1:0] u_tag;
  logic [NU-1:0] u_busy, u_done, u_overflow;
  logic [NU*TW-1:0] u_done_tag;
  logic [NU*DW-1:0] u_result;
  logic          out_valid, out_ready, out_overflow, out_illegal, proto_err;
  logic [DW-1:0] out_result;
  logic [TW:0]   occupancy;

  always #5 clk = ~clk;

  fp_dispatch_rob #(
    .DATA_W(DW), .OPSEL_W(3), .NUM_UNITS(NU), .ROB_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op1(in_op1), .in_op2(in_op2), .in_op_sel(in_op_sel),
    .u_start(u_start), .u_op1(u_op1), .u_op2(u_op2), .u_mode(u_mode), .u_tag(u_tag),
    .u_busy(u_busy), .u_done(u_done), .u_done_tag(u_done_tag), .u_result(u_result),
    .u_overflow(u_overflow), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_overflow(out_overflow), .out_illegal(out_illegal),
    .occupancy(occupancy), .proto_err(proto_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: tags in issue order plus per-tag completion record.
  int          q[$];
  bit          m_done[DEPTH];
  logic [31:0] m_res[DEPTH];
  bit          m_ovf[DEPTH];
  bit          m_ill[DEPTH];
  int          issued;
  bit          m_perr;

  // Emulated units used by the random phase.
  typedef struct {
    int          unit;
    int          tag;
    int          due;
    logic [31:0] res;
    bit          ovf;
  } pend_t;
  pend_t pend[$];
  bit    rand_mode;
  int    cyc;

  task automatic idle();
    rst = 1'b0; in_valid = 1'b0; in_op_sel = OP_ADD; in_op1 = '0; in_op2 = '0;
    u_busy = '0; u_done = '0; u_done_tag = '0; u_result = '0; u_overflow = '0;
    out_ready = 1'b0;
  endtask

  task automatic model_reset();
    q.delete();
    pend.delete();
    issued = 0;
    m_perr = 1'b0;
    foreach (m_done[k]) m_done[k] = 1'b0;
  endtask

  // One clock: check outputs at the falling edge, then advance the model at the rising edge.
  task automatic step();
    bit         ill, rdy, acc, ov, live;
    int         unit, t;
    logic [2:0] st;
    @(negedge clk);
    ill  = (in_op_sel > OP_SIN);
    unit = int'(in_op_sel);
    rdy  = (q.size() < DEPTH) && (ill ? 1'b1 : !u_busy[unit]);
    acc  = in_valid && rdy;
    st   = (acc && !ill) ? 3'(1 << unit) : 3'b000;
    ov   = (q.size() != 0) && m_done[q[0]];
    check("in_ready", 64'(in_ready), 64'(rdy));
    check("u_start", 64'(u_start), 64'(st));
    if (st != 3'b000) begin
      check("u_tag", 64'(u_tag), 64'(issued % DEPTH));
      check("u_op1", 64'(u_op1), 64'(in_op1));
      check("u_op2", 64'(u_op2), 64'(in_op2));
      check("u_mode", 64'(u_mode), 64'(in_op_sel));
    end
    check("out_valid", 64'(out_valid), 64'(ov));
    if (ov) begin
      check("out_result", 64'(out_result), 64'(m_res[q[0]]));
      check("out_overflow", 64'(out_overflow), 64'(m_ovf[q[0]]));
      check("out_illegal", 64'(out_illegal), 64'(m_ill[q[0]]));
    end
    check("occupancy", 64'(occupancy), 64'(q.size()));
    check("proto_err", 64'(proto_err), 64'(m_perr));
    @(posedge clk);
    cyc++;
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < NU; i++) begin
        if (u_done[i]) begin
          live = 1'b0;
          t = int'(u_done_tag[i*TW +: TW]);
          foreach (q[k]) if (q[k] == t) live = 1'b1;
          if (live && !m_done[t]) begin
            m_done[t] = 1'b1;
            m_res[t]  = u_result[i*DW +: DW];
            m_ovf[t]  = u_overflow[i];
          end else begin
            m_perr = 1'b1;
          end
        end
      end
      if (ov && out_ready) begin
        m_done[q[0]] = 1'b0;
        void'(q.pop_front());
      end
      if (acc) begin
        t = issued % DEPTH;
        issued++;
        q.push_back(t);
        m_ill[t] = ill; m_done[t] = ill; m_res[t] = '0; m_ovf[t] = 1'b0;
        if (!ill && rand_mode)
          pend.push_back('{unit, t, cyc + int'($urandom_range(0, 5)), $urandom, 1'($urandom_range(0, 1))});
      end
    end
    #1;
  endtask

  task automatic rand_drive();
    idle();
    in_valid  = ($urandom_range(0, 3) != 0);
    in_op_sel = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
    in_op1    = $urandom;
    in_op2    = $urandom;
    for (int i = 0; i < NU; i++) u_busy[i] = ($urandom_range(0, 3) == 0);
    out_ready = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < NU; i++) begin
      for (int k = 0; k < pend.size(); k++) begin
        if (pend[k].unit == i && pend[k].due <= cyc) begin
          u_done[i]               = 1'b1;
          u_done_tag[i*TW +: TW]  = TW'(pend[k].tag);
          u_result[i*DW +: DW]    = pend[k].res;
          u_overflow[i]           = pend[k].ovf;
          pend.delete(k);
          break;
        end
      end
    end
    // Occasional spurious completion with an arbitrary tag.
    if (!u_done[2] && $urandom_range(0, 199) == 0) begin
      u_done[2]        = 1'b1;
      u_done_tag[5:4]  = 2'($urandom_range(0, 3));
      u_result[95:64]  = $urandom;
    end
  endtask

  int t_a, t_b;

  initial begin
    cyc = 0;
    rand_mode = 1'b0;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    model_reset();

    // Reset state.
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_result", 64'(out_result), 64'd0);
    check("rst_out_illegal", 64'(out_illegal), 64'd0);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    check("rst_proto_err", 64'(proto_err), 64'd0);
    check("rst_u_start", 64'(u_start), 64'd0);
    @(posedge clk); #1;

    // Single add, unit 0 completes three cycles after issue.
    in_valid = 1'b1; in_op_sel = OP_ADD; in_op1 = 32'h3F800000; in_op2 = 32'h40000000;
    step();
    idle(); step(); step();
    u_done = 3'b001; u_done_tag[1:0] = 2'd0; u_result[31:0] = 32'h40400000;
    step();
    idle(); out_ready = 1'b1;
    step();

    // Mul then add; add finishes first but must wait behind mul.
    idle(); in_valid = 1'b1; in_op_sel = OP_MUL; in_op1 = 32'h12345678; in_op2 = 32'h9ABCDEF0;
    t_a = issued % DEPTH; step();
    in_op_sel = OP_ADD; t_b = issued % DEPTH; step();
    idle(); u_done = 3'b001; u_done_tag[1:0] = TW'(t_b); u_result[31:0] = 32'h11111111;
    step();
    idle(); out_ready = 1'b1; repeat (3) step();
    u_done = 3'b010; u_done_tag[3:2] = TW'(t_a); u_result[63:32] = 32'h22222222; u_overflow[1] = 1'b1;
    step();
    idle(); out_ready = 1'b1; repeat (3) step();

    // Illegal op_sel on an empty ROB.
    idle(); in_valid = 1'b1; in_op_sel = 3'd5; in_op1 = 32'hDEADBEEF;
    step();
    idle(); out_ready = 1'b1; repeat (2) step();

    // Fill all entries with out_ready low, then free one.
    idle(); in_valid = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      in_op_sel = 3'(3 + k);
      step();
    end
    in_op_sel = 3'd7; step();
    out_ready = 1'b1; step();
    step();
    idle(); out_ready = 1'b1; repeat (6) step();

    // Two units complete in one cycle with crossed tags, then a stale completion.
    idle(); in_valid = 1'b1; in_op_sel = OP_ADD; t_a = issued % DEPTH; step();
    in_op_sel = OP_MUL; t_b = issued % DEPTH; step();
    idle(); u_done = 3'b011;
    u_done_tag[1:0] = TW'(t_b); u_result[31:0]  = 32'hAAAA0001;
    u_done_tag[3:2] = TW'(t_a); u_result[63:32] = 32'hBBBB0002; u_overflow[1] = 1'b1;
    step();
    idle(); u_done = 3'b001; u_done_tag[1:0] = TW'(t_a); u_result[31:0] = 32'hCCCCCCCC;
    step();
    idle(); out_ready = 1'b1; repeat (3) step();

    // Reset with an op in flight.
    idle(); in_valid = 1'b1; in_op_sel = OP_SIN; step();
    idle(); rst = 1'b1; step();
    idle(); repeat (2) step();

    // Randomized traffic with one reset in the middle.
    rand_mode = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      rand_drive();
      if (n == 1500) rst = 1'b1;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
